// File: rtl/cpu_decode.sv
// ----------------------------------------------------------------------------
// cpu_decode
//  RV32I instruction-decode stage sitting directly behind cpu_fetch.
//  Splits the instruction into its fields, builds the sign-extended
//  immediate, reads the 32x32 integer register file (owned here, written by
//  writeback) and registers the result into the ID/EX pipeline register.
//  The ID/EX register can be held (stall) or replaced with a bubble (flush).
//
// Ports
//  i_clk         clock, rising edge
//  i_rst_n       asynchronous reset, active low
//  i_if_valid    fetch presents a valid instruction
//  i_if_instr    instruction word from fetch
//  i_if_pc       PC of i_if_instr
//  i_stall       hold the ID/EX register
//  i_flush       replace the ID/EX register with a bubble (wins over stall)
//  i_wb_we       writeback write enable
//  i_wb_rd       writeback destination register
//  i_wb_data     writeback data
//  o_id_valid    ID/EX slot holds a real instruction
//  o_id_pc       registered PC
//  o_id_instr    registered instruction word
//  o_id_opcode / o_id_rd / o_id_funct3 / o_id_rs1 / o_id_rs2 / o_id_funct7
//                fields of the registered instruction word
//  o_id_rs1_data register-file value of rs1
//  o_id_rs2_data register-file value of rs2
//  o_id_imm      sign-extended immediate
//  o_id_illegal  opcode outside the RV32I base set (meaningful when valid)
// ----------------------------------------------------------------------------
module cpu_decode #(
   parameter int          XLEN     = 32,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_if_valid,
   input  logic [31:0]     i_if_instr,
   input  logic [31:0]     i_if_pc,
   input  logic            i_stall,
   input  logic            i_flush,
   input  logic            i_wb_we,
   input  logic [4:0]      i_wb_rd,
   input  logic [XLEN-1:0] i_wb_data,
   output logic            o_id_valid,
   output logic [31:0]     o_id_pc,
   output logic [31:0]     o_id_instr,
   output logic [6:0]      o_id_opcode,
   output logic [4:0]      o_id_rd,
   output logic [2:0]      o_id_funct3,
   output logic [4:0]      o_id_rs1,
   output logic [4:0]      o_id_rs2,
   output logic [6:0]      o_id_funct7,
   output logic [XLEN-1:0] o_id_rs1_data,
   output logic [XLEN-1:0] o_id_rs2_data,
   output logic [31:0]     o_id_imm,
   output logic            o_id_illegal
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   logic [XLEN-1:0] r_regs [32];

   logic [31:0]     r_pc;
   logic [31:0]     r_instr;
   logic            r_valid;
   logic [XLEN-1:0] r_rs1Data;
   logic [XLEN-1:0] r_rs2Data;
   logic [31:0]     r_imm;
   logic            r_illegal;

   logic [6:0]      w_opcode;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic            w_wbHit;
   logic [XLEN-1:0] w_rs1Data;
   logic [XLEN-1:0] w_rs2Data;
   logic [31:0]     w_imm;
   logic            w_illegal;

   assign w_opcode = i_if_instr[6:0];
   assign w_rs1    = i_if_instr[19:15];
   assign w_rs2    = i_if_instr[24:20];

   // A write to x0 is dropped everywhere, so one qualifier serves both the
   // register file and the forwarding paths.
   assign w_wbHit  = i_wb_we && (i_wb_rd != 5'd0);

   // Same-edge writeback is forwarded so the captured operand is never the
   // value that is being overwritten on this very edge.
   assign w_rs1Data = (w_rs1 == 5'd0)                  ? '0        :
                      (w_wbHit && (i_wb_rd == w_rs1)) ? i_wb_data : r_regs[w_rs1];
   assign w_rs2Data = (w_rs2 == 5'd0)                  ? '0        :
                      (w_wbHit && (i_wb_rd == w_rs2)) ? i_wb_data : r_regs[w_rs2];

   always_comb begin
      w_imm     = '0;
      w_illegal = 1'b0;
      case (w_opcode)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
            w_imm = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
         OP_STORE:
            w_imm = {{20{i_if_instr[31]}}, i_if_instr[31:25], i_if_instr[11:7]};
         OP_BRANCH:
            w_imm = {{19{i_if_instr[31]}}, i_if_instr[31], i_if_instr[7],
                     i_if_instr[30:25], i_if_instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            w_imm = {i_if_instr[31:12], 12'b0};
         OP_JAL:
            w_imm = {{11{i_if_instr[31]}}, i_if_instr[31], i_if_instr[19:12],
                     i_if_instr[20], i_if_instr[30:21], 1'b0};
         OP_REG, OP_FENCE:
            w_imm = '0;
         default:
            w_illegal = 1'b1;
      endcase
   end

   // Register file. Writes are independent of stall/flush; x0 is never
   // written and is also masked on read.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wbHit) begin
         r_regs[i_wb_rd] <= i_wb_data;
      end
   end

   // ID/EX register: flush > stall > load. An invalid fetch slot loads a
   // bubble just like a flush does.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_instr   <= NOP_INSN;
         r_rs1Data <= '0;
         r_rs2Data <= '0;
         r_imm     <= '0;
         r_illegal <= 1'b0;
      end else if (i_flush || (!i_stall && !i_if_valid)) begin
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_instr   <= NOP_INSN;
         r_rs1Data <= '0;
         r_rs2Data <= '0;
         r_imm     <= '0;
         r_illegal <= 1'b0;
      end else if (i_stall) begin
         // Held operands track writeback so they are current when the
         // stall releases.
         if (w_wbHit && (i_wb_rd == r_instr[19:15])) begin
            r_rs1Data <= i_wb_data;
         end
         if (w_wbHit && (i_wb_rd == r_instr[24:20])) begin
            r_rs2Data <= i_wb_data;
         end
      end else begin
         r_valid   <= 1'b1;
         r_pc      <= i_if_pc;
         r_instr   <= i_if_instr;
         r_rs1Data <= w_rs1Data;
         r_rs2Data <= w_rs2Data;
         r_imm     <= w_imm;
         r_illegal <= w_illegal;
      end
   end

   assign o_id_valid    = r_valid;
   assign o_id_pc       = r_pc;
   assign o_id_instr    = r_instr;
   assign o_id_opcode   = r_instr[6:0];
   assign o_id_rd       = r_instr[11:7];
   assign o_id_funct3   = r_instr[14:12];
   assign o_id_rs1      = r_instr[19:15];
   assign o_id_rs2      = r_instr[24:20];
   assign o_id_funct7   = r_instr[31:25];
   assign o_id_rs1_data = r_rs1Data;
   assign o_id_rs2_data = r_rs2Data;
   assign o_id_imm      = r_imm;
   assign o_id_illegal  = r_illegal;

endmodule
